// File: rtl/jk_seq_ctrl.sv
// ============================================================================
// Module   : jk_seq_ctrl
// Brief    : Command sequencer driving a WIDTH-bit JK flip-flop bank
//            (load / count-up / count-down / toggle over valid/ready).
//            Optional JKSEQ_SATURATE_EN: counts hold at the range limits.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]       c_op_load  = 2'b00;
    localparam logic [1:0]       c_op_up    = 2'b01;
    localparam logic [1:0]       c_op_down  = 2'b10;
    localparam logic [1:0]       c_op_tog   = 2'b11;
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;

    logic [WIDTH-1:0] w_up_en;
    logic [WIDTH-1:0] w_dn_en;
    logic             w_is_count;
    logic             w_accept;

    // Bit i toggles on up-count when all lower bits are 1, on down-count when all are 0.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
        localparam logic [WIDTH-1:0] c_mask = (WIDTH'(1) << gi) - WIDTH'(1);
        assign w_up_en[gi] = &(r_q | ~c_mask);
        assign w_dn_en[gi] = ~|(r_q & c_mask);
    end

    assign cmd_ready  = rst && (r_state == ST_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_is_count = (cmd_op == c_op_up) || (cmd_op == c_op_down);
    assign busy       = (r_state == ST_EXEC) || (r_state == ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign q          = r_q;

    always_comb begin
        j = '0;
        k = '0;
        if (r_state == ST_EXEC) begin
            case (r_op)
                c_op_load: begin
                    j = r_data;
                    k = ~r_data;
                end
                c_op_up: begin
`ifdef JKSEQ_SATURATE_EN
                    if (!(&r_q)) begin
                        j = w_up_en;
                        k = w_up_en;
                    end
`else
                    j = w_up_en;
                    k = w_up_en;
`endif
                end
                c_op_down: begin
`ifdef JKSEQ_SATURATE_EN
                    if (|r_q) begin
                        j = w_dn_en;
                        k = w_dn_en;
                    end
`else
                    j = w_dn_en;
                    k = w_dn_en;
`endif
                end
                default: begin
                    j = r_data;
                    k = r_data;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= c_op_load;
            r_data  <= '0;
            r_cnt   <= '0;
            r_q     <= '0;
        end else begin
            r_q <= (j & ~r_q) | (~k & r_q);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                        r_cnt  <= w_is_count ? cmd_data : c_one;
                        // A zero-step count has nothing to execute.
                        if (w_is_count && (cmd_data == '0))
                            r_state <= ST_DONE;
                        else
                            r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt - c_one;
                    if (r_cnt == c_one)
                        r_state <= ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jk_seq_ctrl.sv
// ============================================================================
// Module   : tb_jk_seq_ctrl
// Brief    : Directed, table-driven self-checking bench for jk_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_seq_ctrl;

`ifdef JKSEQ_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    jk_seq_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .j         (j),
        .k         (k),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] exp_wrap;
        logic [3:0] exp_sat;
        int         exp_lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command, wait (bounded) for done, check latency and final q.
    task automatic do_cmd(input string nm, input logic [1:0] op, input logic [3:0] d,
                          input logic [3:0] exp_q, input int exp_lat);
        int lat;
        chk({nm, ".ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = 4'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            step();
            lat++;
        end
        chk({nm, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, ".q"}, 32'(q), 32'(exp_q));
        step();
        chk({nm, ".done_clr"}, 32'({done, cmd_ready, busy}), 32'(3'b010));
    endtask

    initial begin
        int lat;
        bit seen_done;

        vecs[0]  = '{2'b00, 4'hE, 4'hE, 4'hE, 1};
        vecs[1]  = '{2'b01, 4'h3, 4'h1, 4'hF, 3};
        vecs[2]  = '{2'b10, 4'h2, 4'hF, 4'hD, 2};
        vecs[3]  = '{2'b00, 4'hA, 4'hA, 4'hA, 1};
        vecs[4]  = '{2'b11, 4'h5, 4'hF, 4'hF, 1};
        vecs[5]  = '{2'b01, 4'h0, 4'hF, 4'hF, 0};
        vecs[6]  = '{2'b10, 4'h0, 4'hF, 4'hF, 0};
        vecs[7]  = '{2'b00, 4'h0, 4'h0, 4'h0, 1};
        vecs[8]  = '{2'b10, 4'h1, 4'hF, 4'h0, 1};
        vecs[9]  = '{2'b01, 4'hF, 4'hE, 4'hF, 15};
        vecs[10] = '{2'b11, 4'hF, 4'h1, 4'h0, 1};
        vecs[11] = '{2'b00, 4'h5, 4'h5, 4'h5, 1};
        vecs[12] = '{2'b01, 4'h2, 4'h7, 4'h7, 2};
        vecs[13] = '{2'b11, 4'h0, 4'h7, 4'h7, 1};

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'h0;

        // Reset
        step();
        chk("rst.ready_in_reset", 32'(cmd_ready), 32'd0);
        step();
        chk("rst.q", 32'(q), 32'd0);
        chk("rst.jk", 32'({j, k}), 32'd0);
        chk("rst.flags", 32'({done, busy, cmd_ready}), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst.ready_after", 32'(cmd_ready), 32'd1);

        // LOAD 0xA, cycle by cycle
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = 4'hA;
        step();
        cmd_valid = 1'b0;
        chk("loadA.j", 32'(j), 32'hA);
        chk("loadA.k", 32'(k), 32'h5);
        chk("loadA.exec_flags", 32'({busy, done, cmd_ready}), 32'(3'b100));
        step();
        chk("loadA.q", 32'(q), 32'hA);
        chk("loadA.done_flags", 32'({busy, done, cmd_ready}), 32'(3'b110));
        chk("loadA.done_jk", 32'({j, k}), 32'd0);
        step();
        chk("loadA.after_flags", 32'({busy, done, cmd_ready}), 32'(3'b001));

        // Count-up across the wrap point, edge by edge
        do_cmd("seq.loadE", 2'b00, 4'hE, 4'hE, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'h3;
        step();
        cmd_valid = 1'b0;
        chk("seq.up_j", 32'(j), 32'h1);
        step();
        chk("seq.up_q1", 32'(q), 32'hF);
        step();
        chk("seq.up_q2", 32'(q), SAT ? 32'hF : 32'h0);
        chk("seq.up_nodone", 32'(done), 32'd0);
        step();
        chk("seq.up_q3", 32'(q), SAT ? 32'hF : 32'h1);
        chk("seq.up_done", 32'(done), 32'd1);
        step();
        do_cmd("seq.down2", 2'b10, 4'h2, SAT ? 4'hD : 4'hF, 2);

        // Table-driven command stream
        for (int i = 0; i < 14; i++)
            do_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data,
                   SAT ? vecs[i].exp_sat : vecs[i].exp_wrap, vecs[i].exp_lat);

        // Reset in the middle of a count
        do_cmd("mid.load0", 2'b00, 4'h0, 4'h0, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'hA;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid.q4", 32'(q), 32'h4);
        rst = 1'b0;
        step();
        chk("mid.q_rst", 32'(q), 32'h0);
        chk("mid.flags_rst", 32'({busy, done, cmd_ready}), 32'd0);
        rst = 1'b1;
        #1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) seen_done = 1'b1;
            step();
        end
        chk("mid.no_done", 32'(seen_done), 32'd0);
        do_cmd("mid.load3", 2'b00, 4'h3, 4'h3, 1);

        // Command inputs wiggling while busy must be ignored
        do_cmd("hs.load0", 2'b00, 4'h0, 4'h0, 1);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_data  = 4'h3;
        step();
        lat = 0;
        while (!done && lat < 40) begin
            cmd_op   = 2'(lat);
            cmd_data = 4'(lat * 5 + 9);
            step();
            lat++;
        end
        chk("hs.lat", 32'(lat), 32'd3);
        chk("hs.q", 32'(q), 32'h3);
        cmd_valid = 1'b0;
        step();
        chk("hs.after", 32'({busy, cmd_ready, q}), 32'({1'b0, 1'b1, 4'h3}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jk_seq_ctrl.md
# jk_seq_ctrl

Command-driven sequencer for a WIDTH-bit bank of JK flip-flops. It accepts load, count-up, count-down and toggle commands over a valid/ready handshake and drives the per-bit J/K inputs each cycle to carry them out. The bank state is held internally and exposed on `q`, so the block is the controller plus the register bank it owns. It sits between a command source (bench, host FSM) and any logic consuming the JK register value.

## Interface
- `WIDTH`, default 4: number of JK flip-flops in the bank; also the width of `cmd_data`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_op` in 2: command code.
  - 00 LOAD
  - 01 COUNT_UP
  - 10 COUNT_DOWN
  - 11 TOGGLE
- `cmd_data` in WIDTH: meaning depends on `cmd_op`.
  - LOAD: load value.
  - COUNT_UP / COUNT_DOWN: step count.
  - TOGGLE: toggle mask.
- `j` out WIDTH: per-bit J drive to the bank.
- `k` out WIDTH: per-bit K drive to the bank.
- `q` out WIDTH: current bank state.
- `busy` out 1: high in EXEC and DONE.
- `done` out 1: one-cycle completion pulse.

## Operation
- **Bank update, every edge when `rst`=1:** `q[i] <= (j[i] & ~q[i]) | (~k[i] & q[i])`, using the standard JK behaviour (00 hold, 01 reset, 10 set, 11 toggle).
- **FSM states:** IDLE, EXEC, DONE.
- **IDLE:**
  - `cmd_ready`=1, `j`=`k`=0.
  - On `cmd_valid & cmd_ready`, latch `cmd_op` and `cmd_data`.
  - If the op is COUNT_UP or COUNT_DOWN and `cmd_data`=0, go to DONE.
  - Otherwise go to EXEC.
  - The step counter is loaded with `cmd_data` for counts and with 1 for LOAD and TOGGLE.
- **EXEC:** `cmd_ready`=0. J/K drive per latched op:
  - LOAD: `j`=d, `k`=~d.
  - TOGGLE: `j`=`k`=mask.
  - COUNT_UP: `j[i]`=`k[i]`=&q[i-1:0]; bit 0 is always 1.
  - COUNT_DOWN: `j[i]`=`k[i]`=~|q[i-1:0]; bit 0 is always 1.
  - The step counter decrements each cycle. When it reaches 1, the next state is DONE.
- **DONE:** `j`=`k`=0, `done`=1, `cmd_ready`=0. Next state is IDLE.
- **Arithmetic:** modulo 2^WIDTH. Up-count wraps all-ones to 0; down-count wraps 0 to all-ones.
- **Step counter:** WIDTH bits wide, so at most 2^WIDTH−1 steps per command.
- `cmd_valid` outside IDLE is ignored. The command source holds the command until it sees `cmd_ready`.
- `cmd_op` and `cmd_data` changes after acceptance have no effect.

## Timing
- **Reset values (at the edge with `rst`=0):**
  - State is IDLE and `q`=0.
  - `j`=`k`=0, `done`=0, `busy`=0.
  - `cmd_ready` is forced to 0 while `rst`=0 and rises in the first cycle with `rst`=1.
- **Reset mid-operation:** the command is aborted, `q`=0 at that edge and no `done` pulse is produced.
- **Reference edge:** the command is accepted at edge A.
- **LOAD / TOGGLE:**
  - EXEC runs in cycle A..A+1 and `q` updates at edge A+1.
  - `done`=1 in cycle A+1..A+2.
  - The earliest next acceptance is at edge A+2.
- **COUNT N (N≥1):**
  - `q` updates at edges A+1..A+N.
  - `done`=1 in cycle A+N..A+N+1.
  - The earliest next acceptance is at edge A+N+1.
- **COUNT 0:** `q` is unchanged, `done`=1 in cycle A..A+1 and the next acceptance is at edge A+1.
- **Throughput:** one command per (steps+1) cycles at best. There is no back-to-back acceptance, because DONE always inserts one cycle.
- **Output types:**
  - `j`, `k`, `cmd_ready`, `busy` and `done` are combinational from state registers and `q` only, never from the command inputs.
  - `q` is a register.

## Configuration
- **`JKSEQ_SATURATE_EN` defined:**
  - COUNT_UP with `q` all-ones drives `j`=`k`=0 (hold) for that step.
  - COUNT_DOWN with `q`=0 likewise holds.
  - The remaining steps are still consumed, so latency is unchanged.
  - LOAD and TOGGLE are unaffected.
- **Undefined:** counts wrap modulo 2^WIDTH as described in Operation.

## Test plan
All scenarios use WIDTH=4.
- **Reset:** hold `rst`=0 for 2 edges, then release → `q`=0, `j`=`k`=0, `done`=0, `busy`=0; `cmd_ready`=0 during reset and 1 in the first cycle after release.
- **LOAD 0xA** → during EXEC `j`=1010, `k`=0101; `q`=0xA one edge after accept; `done` is a single-cycle pulse; `cmd_ready` returns 1 two edges after accept.
- **Counting:**
  - LOAD 0xE, then COUNT_UP 3 → `q` sequence 0xF, 0x0, 0x1 on successive edges.
  - Then COUNT_DOWN 2 → `q` 0x0, 0xF.
  - With `JKSEQ_SATURATE_EN` defined, 0xE up 3 gives 0xF, 0xF, 0xF.
- **TOGGLE and zero-step count:**
  - LOAD 0xA, then TOGGLE 0x5 → `q`=0xF.
  - Then COUNT_UP 0 → `done` in the cycle right after acceptance and `q` stays 0xF.
- **Reset mid-operation:** COUNT_UP 10 from 0x0, drive `rst`=0 after 4 edges (`q`=0x4) → `q`=0 at the reset edge, no `done` pulse, and the next command after release is accepted normally.
- **Handshake:** keep `cmd_valid`=1 with changing `cmd_op`/`cmd_data` while `busy`=1 → no extra command is accepted and the latched command completes unchanged.
